// File: rtl/ahb_params_pkg.sv
// Shared AHB encodings and arbiter helpers.
//   htrans_e / hresp_e : AHB transfer type and slave response encodings
//   ARB_FIXED / ARB_RR : arbitration mode selectors
//   onehot_to_idx      : index of the set bit in a one-hot vector (up to 16)
package ahb_params_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        OKAY  = 2'd0,
        ERROR = 2'd1,
        RETRY = 2'd2,
        SPLIT = 2'd3
    } hresp_e;

    localparam int ARB_FIXED   = 0;
    localparam int ARB_RR      = 1;
    localparam int MAX_MASTERS = 16;
    localparam int MAX_IDX_W   = 4;

    // OR of the indices of all set bits; exact for a one-hot input.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_rr_prio_sel.sv
// Combinational masked priority select.
//   req       : candidate vector (already masked by the caller)
//   start_ptr : round-robin pointer; search begins at start_ptr+1 (RR mode only)
//   grant     : one-hot winner, zero when req is empty
//   valid     : at least one candidate present
module ahb_rr_prio_sel
    import ahb_params_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = ARB_RR
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start_ptr,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    always_comb begin
        logic        found;
        int unsigned idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            // RR: rotate so start_ptr itself is visited last.
            if (MODE == ARB_RR) idx = 32'(start_ptr) + 1 + k;
            else                idx = k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx[IW-1:0]]) begin
                grant[idx[IW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter with fixed-priority or round-robin selection, burst hold
// limit, locked-sequence hold and SPLIT masking.
//   HCLK, HRESET     : clock, synchronous active-high reset
//   HBUSREQ, HLOCK   : per-master request / locked-transfer request
//   HSPLIT           : per-master split-resume pulses
//   HTRANS, HREADY,
//   HRESP            : shared bus status for the current transfer
//   HGRANT           : one-hot grant
//   HMASTER          : owner of the current address phase
//   HMASTLOCK        : current address phase is locked
module ahb_arbiter_rr
    import ahb_params_pkg::*;
#(
    parameter int NO_OF_MASTERS  = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int ARB_MODE       = ARB_RR,
    parameter int HOLD_LIMIT     = 16
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [NO_OF_MASTERS-1:0]         HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0]         HLOCK,
    input  logic [NO_OF_MASTERS-1:0]         HSPLIT,
    input  logic [1:0]                       HTRANS,
    input  logic                             HREADY,
    input  logic [1:0]                       HRESP,
    output logic [NO_OF_MASTERS-1:0]         HGRANT,
    output logic [$clog2(NO_OF_MASTERS)-1:0] HMASTER,
    output logic                             HMASTLOCK
);

    localparam int NM    = NO_OF_MASTERS;
    localparam int IW    = $clog2(NM);
    localparam int CNT_W = (HOLD_LIMIT > 1) ? $clog2(HOLD_LIMIT) : 1;

    localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(HOLD_LIMIT - 1);
    localparam logic [NM-1:0]    DEF_OH = NM'(1) << DEFAULT_MASTER;

    logic [NM-1:0]    grant_q;
    logic [NM-1:0]    split_mask;
    logic [NM-1:0]    split_set;
    logic [NM-1:0]    split_mask_nxt;
    logic [NM-1:0]    elig;
    logic [NM-1:0]    sel_grant;
    logic             sel_valid;
    logic [NM-1:0]    winner;
    logic [IW-1:0]    winner_idx;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    data_master;
    logic [CNT_W-1:0] beat_cnt;
    logic             owner_locked;
    logic             rearb;
    logic             grant_chg;
    htrans_e          trans;
    hresp_e           resp;

    assign trans = htrans_e'(HTRANS);
    assign resp  = hresp_e'(HRESP);
    assign owner = IW'(onehot_to_idx(16'(grant_q)));

    // The split master is excluded from the arbitration taken on the very
    // edge that records the SPLIT, hence the use of the next mask value.
    assign split_set      = (HREADY && resp == SPLIT) ? (NM'(1) << data_master) : '0;
    assign split_mask_nxt = (split_mask & ~HSPLIT) | split_set;
    assign elig           = HBUSREQ & ~split_mask_nxt;

    ahb_rr_prio_sel #(
        .N    (NM),
        .MODE (ARB_MODE)
    ) u_sel (
        .req       (elig),
        .start_ptr (rr_ptr),
        .grant     (sel_grant),
        .valid     (sel_valid)
    );

    assign winner     = sel_valid ? sel_grant : DEF_OH;
    assign winner_idx = IW'(onehot_to_idx(16'(winner)));

    // A lock pins the grant unless its owner has just been split away.
    assign owner_locked = HLOCK[owner] && !split_mask_nxt[owner];
    assign rearb = HREADY && !owner_locked &&
                   (trans == IDLE || trans == NONSEQ || beat_cnt == LIM_M1 ||
                    resp == SPLIT || resp == RETRY);
    assign grant_chg = rearb && (winner != grant_q);

    assign HGRANT = grant_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q     <= DEF_OH;
            HMASTER     <= IW'(DEFAULT_MASTER);
            HMASTLOCK   <= 1'b0;
            split_mask  <= '0;
            rr_ptr      <= IW'(DEFAULT_MASTER);
            beat_cnt    <= '0;
            data_master <= IW'(DEFAULT_MASTER);
        end else begin
            split_mask <= split_mask_nxt;
            if (HREADY) begin
                HMASTER     <= owner;
                HMASTLOCK   <= HLOCK[owner] && !split_mask_nxt[owner];
                data_master <= HMASTER;
                if (grant_chg) begin
                    grant_q  <= winner;
                    beat_cnt <= '0;
                    if (sel_valid) rr_ptr <= winner_idx;
                end else if (trans == IDLE || trans == NONSEQ) begin
                    beat_cnt <= '0;
                end else if (trans == SEQ && beat_cnt != LIM_M1) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
module tb_ahb_arbiter_rr;
    import ahb_params_pkg::*;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] HBUSREQ, HLOCK, HSPLIT;
    logic [1:0] HTRANS, HRESP;
    logic       HREADY;

    logic [3:0] rr_grant, fx_grant;
    logic [1:0] rr_master, fx_master;
    logic       rr_lock, fx_lock;

    int n_pass  = 0;
    int n_total = 0;

    always #5 HCLK = ~HCLK;

    ahb_arbiter_rr #(
        .NO_OF_MASTERS  (4),
        .DEFAULT_MASTER (0),
        .ARB_MODE       (1),
        .HOLD_LIMIT     (4)
    ) dut_rr (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HSPLIT    (HSPLIT),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HGRANT    (rr_grant),
        .HMASTER   (rr_master),
        .HMASTLOCK (rr_lock)
    );

    ahb_arbiter_rr #(
        .NO_OF_MASTERS  (4),
        .DEFAULT_MASTER (0),
        .ARB_MODE       (0),
        .HOLD_LIMIT     (4)
    ) dut_fx (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HSPLIT    (HSPLIT),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HGRANT    (fx_grant),
        .HMASTER   (fx_master),
        .HMASTLOCK (fx_lock)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] hsplit;
        logic [1:0] trans;
        logic       ready;
        logic [1:0] resp;
        logic [3:0] exp_grant;
        logic [1:0] exp_master;
        logic       exp_lock;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                       input logic [3:0] hs, input logic [1:0] tr, input logic rdy,
                       input logic [1:0] rsp, input logic [3:0] eg, input logic [1:0] em,
                       input logic el);
        vec_t v;
        v.rst = rst; v.req = req; v.lock = lock; v.hsplit = hs; v.trans = tr;
        v.ready = rdy; v.resp = rsp;
        v.exp_grant = eg; v.exp_master = em; v.exp_lock = el;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                         input logic [3:0] hs, input logic [1:0] tr, input logic rdy,
                         input logic [1:0] rsp);
        HRESET = rst; HBUSREQ = req; HLOCK = lock; HSPLIT = hs;
        HTRANS = tr; HREADY = rdy; HRESP = rsp;
    endtask

    task automatic fx_step(input int idx, input logic rst, input logic [3:0] req,
                           input logic [1:0] tr, input logic [3:0] eg, input logic [1:0] em);
        drive(rst, req, 4'b0000, 4'b0000, tr, 1'b1, OKAY);
        @(posedge HCLK); #1;
        check("fx_grant", idx, fx_grant, eg);
        check("fx_master", idx, {2'b00, fx_master}, {2'b00, em});
        check("fx_lock", idx, {3'b000, fx_lock}, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b1, 4'b0000, 4'b0000, 4'b0000, IDLE, 1'b1, OKAY);

        // reset state
        add(1, 4'b0000, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0001, 2'd0, 0);
        add(1, 4'b0000, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0001, 2'd0, 0);
        // round-robin rotation, HMASTER one cycle behind
        add(0, 4'b1111, 4'b0000, 4'b0000, NONSEQ, 1, OKAY,  4'b0010, 2'd0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0000, NONSEQ, 1, OKAY,  4'b0100, 2'd1, 0);
        add(0, 4'b1111, 4'b0000, 4'b0000, NONSEQ, 1, OKAY,  4'b1000, 2'd2, 0);
        add(0, 4'b1111, 4'b0000, 4'b0000, NONSEQ, 1, OKAY,  4'b0001, 2'd3, 0);
        add(0, 4'b1111, 4'b0000, 4'b0000, NONSEQ, 1, OKAY,  4'b0010, 2'd0, 0);
        // master 2 burst, master 1 competing; hold limit ends it
        add(0, 4'b0100, 4'b0000, 4'b0000, NONSEQ, 1, OKAY,  4'b0100, 2'd1, 0);
        add(0, 4'b0100, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0100, 2'd2, 0);
        add(0, 4'b0100, 4'b0000, 4'b0000, NONSEQ, 1, OKAY,  4'b0100, 2'd2, 0);
        add(0, 4'b0110, 4'b0000, 4'b0000, SEQ,    1, OKAY,  4'b0100, 2'd2, 0);
        add(0, 4'b0110, 4'b0000, 4'b0000, SEQ,    1, OKAY,  4'b0100, 2'd2, 0);
        add(0, 4'b0110, 4'b0000, 4'b0000, SEQ,    1, OKAY,  4'b0100, 2'd2, 0);
        add(0, 4'b0110, 4'b0000, 4'b0000, SEQ,    1, OKAY,  4'b0010, 2'd2, 0);
        add(0, 4'b0110, 4'b0000, 4'b0000, SEQ,    1, OKAY,  4'b0010, 2'd1, 0);
        // locked burst of 10 beats ignores the hold limit
        add(0, 4'b0100, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0100, 2'd1, 0);
        add(0, 4'b0100, 4'b0100, 4'b0000, IDLE,   1, OKAY,  4'b0100, 2'd2, 1);
        add(0, 4'b0110, 4'b0100, 4'b0000, NONSEQ, 1, OKAY,  4'b0100, 2'd2, 1);
        for (int i = 0; i < 9; i++)
            add(0, 4'b0110, 4'b0100, 4'b0000, SEQ, 1, OKAY, 4'b0100, 2'd2, 1);
        add(0, 4'b0110, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0010, 2'd2, 0);
        // master 1 reaches data phase, then two-cycle SPLIT
        add(0, 4'b0010, 4'b0000, 4'b0000, NONSEQ, 1, OKAY,  4'b0010, 2'd1, 0);
        add(0, 4'b0010, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0010, 2'd1, 0);
        add(0, 4'b1010, 4'b0000, 4'b0000, IDLE,   0, SPLIT, 4'b0010, 2'd1, 0);
        add(0, 4'b1010, 4'b0000, 4'b0000, IDLE,   1, SPLIT, 4'b1000, 2'd1, 0);
        add(0, 4'b0010, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0001, 2'd3, 0);
        add(0, 4'b0010, 4'b0000, 4'b0010, IDLE,   1, OKAY,  4'b0010, 2'd0, 0);
        // HREADY low freezes everything
        add(0, 4'b1110, 4'b0000, 4'b0000, NONSEQ, 0, OKAY,  4'b0010, 2'd0, 0);
        add(0, 4'b1110, 4'b0000, 4'b0000, NONSEQ, 0, OKAY,  4'b0010, 2'd0, 0);
        add(0, 4'b1110, 4'b0000, 4'b0000, NONSEQ, 0, OKAY,  4'b0010, 2'd0, 0);
        add(0, 4'b1110, 4'b0000, 4'b0000, NONSEQ, 1, OKAY,  4'b0100, 2'd1, 0);
        // split master 2, master 3 locks, reset mid-lock
        add(0, 4'b0100, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0100, 2'd2, 0);
        add(0, 4'b0100, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0100, 2'd2, 0);
        add(0, 4'b1100, 4'b1000, 4'b0000, IDLE,   1, SPLIT, 4'b1000, 2'd2, 0);
        add(0, 4'b1100, 4'b1000, 4'b0000, NONSEQ, 1, OKAY,  4'b1000, 2'd3, 1);
        add(0, 4'b1100, 4'b1000, 4'b0000, SEQ,    1, OKAY,  4'b1000, 2'd3, 1);
        add(1, 4'b1100, 4'b1000, 4'b0000, SEQ,    1, OKAY,  4'b0001, 2'd0, 0);
        // split mask cleared by reset: master 2 wins again
        add(0, 4'b0100, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0100, 2'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].hsplit,
                  vecs[i].trans, vecs[i].ready, vecs[i].resp);
            @(posedge HCLK); #1;
            check("rr_grant", i, rr_grant, vecs[i].exp_grant);
            check("rr_master", i, {2'b00, rr_master}, {2'b00, vecs[i].exp_master});
            check("rr_lock", i, {3'b000, rr_lock}, {3'b000, vecs[i].exp_lock});
        end

        // fixed priority: lowest index wins, park on master 0 when idle
        fx_step(100, 1'b1, 4'b0000, IDLE,   4'b0001, 2'd0);
        fx_step(101, 1'b0, 4'b1010, NONSEQ, 4'b0010, 2'd0);
        fx_step(102, 1'b0, 4'b1010, NONSEQ, 4'b0010, 2'd1);
        fx_step(103, 1'b0, 4'b1000, NONSEQ, 4'b1000, 2'd1);
        fx_step(104, 1'b0, 4'b0000, IDLE,   4'b0001, 2'd3);
        fx_step(105, 1'b0, 4'b0000, IDLE,   4'b0001, 2'd0);
        fx_step(106, 1'b0, 4'b1110, NONSEQ, 4'b0010, 2'd0);
        fx_step(107, 1'b0, 4'b1111, NONSEQ, 4'b0001, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_rr.md
Name: ahb_arbiter_rr

Overview:
Parametrised AHB bus arbiter for NO_OF_MASTERS masters. It replaces the fixed two-master arbitration with selectable fixed-priority or round-robin arbitration. It adds a burst-beat hold limit, locked-sequence handling and SPLIT masking. It drives HGRANT, HMASTER and HMASTLOCK on the shared AHB interface, alongside the address decoder.

Parameters:
NO_OF_MASTERS, 4, number of masters (2..16).
DEFAULT_MASTER, 0, master parked on when no eligible request; reset owner.
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
HOLD_LIMIT, 16, max beats an unlocked owner keeps the bus while others request (1..256).

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous reset, active-high
HBUSREQ  in  NO_OF_MASTERS  per-master bus request
HLOCK  in  NO_OF_MASTERS  per-master locked-transfer request
HSPLIT  in  NO_OF_MASTERS  OR of slave split-resume vectors; bit i pulse = master i may retry
HTRANS  in  2  transfer type of current address phase
HREADY  in  1  bus ready
HRESP  in  2  slave response
HGRANT  out  NO_OF_MASTERS  one-hot grant
HMASTER  out  $clog2(NO_OF_MASTERS)  master owning current address phase
HMASTLOCK  out  1  current address phase is part of a locked sequence

Behaviour:
- Reset (HRESET=1 at posedge):
  - HGRANT = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER, HMASTLOCK = 0.
  - split_mask = 0, rr_ptr = DEFAULT_MASTER, beat_cnt = 0, data_master = DEFAULT_MASTER.
  - Reset mid-burst or mid-lock applies the same values on the next edge; there is no recovery of prior state.
- Eligible set: elig = HBUSREQ & ~split_mask.
- Winner:
  - ARB_MODE=0: lowest set index of elig.
  - ARB_MODE=1: first set bit searching from rr_ptr+1 upward, wrapping modulo NO_OF_MASTERS. rr_ptr itself is searched last.
  - elig == 0: winner = DEFAULT_MASTER (granted even if split-masked; that master must drive IDLE).
- Re-arbitration (HGRANT update) occurs only at a posedge with HREADY=1 and one of:
  - HTRANS is IDLE or NONSEQ;
  - beat_cnt reached HOLD_LIMIT-1 and no lock is held;
  - owner just split/retried.
- Hold: while the owner has HLOCK=1, HGRANT does not change (lock overrides HOLD_LIMIT). Exception: the owner itself gets split-masked.
- Latency:
  - New HGRANT is visible 1 cycle after the qualifying edge.
  - At each HREADY=1 edge: HMASTER <= index(HGRANT), HMASTLOCK <= HLOCK[index(HGRANT)], data_master <= HMASTER.
  - HMASTER therefore lags HGRANT by one HREADY-qualified cycle (address-phase alignment).
  - HREADY=0 freezes HGRANT, HMASTER, HMASTLOCK, data_master and beat_cnt.
- beat_cnt:
  - Increments on HREADY=1 with HTRANS=SEQ.
  - Clears on NONSEQ/IDLE or on a grant change.
  - Saturates at HOLD_LIMIT-1.
- rr_ptr <= index of newly granted master whenever a grant changes to a requesting master. Parking on DEFAULT_MASTER with no requests does not move rr_ptr.
- SPLIT:
  - HRESP=SPLIT with HREADY=1 (second response cycle) sets split_mask[data_master].
  - The next arbitration excludes that master, and HMASTLOCK is forced to 0 for it.
- HSPLIT[i]=1 clears split_mask[i]. On the same bit in the same cycle, set wins.
- RETRY: no masking; the owner is re-arbitrated normally. ERROR/OKAY have no effect on arbitration.
- HGRANT is always exactly one-hot; HMASTER < NO_OF_MASTERS always.

Decomposition:
- ahb_params_pkg adds:
  - htrans_e: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - hresp_e: OKAY=0, ERROR=1, RETRY=2, SPLIT=3.
  - Constants ARB_FIXED=0, ARB_RR=1.
  - Function onehot_to_idx.
- Sub-module ahb_rr_prio_sel: combinational masked priority select. Parameters N and mode. Inputs req, start_ptr; outputs grant one-hot, valid.

Test Plan:
1. RR, N=4: HBUSREQ=4'b1111 held, single NONSEQ transfers, HREADY=1 -> grants cycle 1,2,3,0,1 (from reset ptr 0). HMASTER follows one cycle later.
2. Fixed, HBUSREQ=4'b1010 -> master 1 granted. Drop bit1 -> master 3 granted after next HREADY edge. HBUSREQ=0 -> park on master 0.
3. Hold limit 4: master 2 runs INCR SEQ burst while master 1 requests -> grant moves to 1 after 4th beat. Repeat with HLOCK[2]=1 -> grant held for the full 10 beats, HMASTLOCK=1.
4. Master 1 owns data phase, HRESP=SPLIT two cycles -> split_mask=4'b0010, master 1 not granted despite HBUSREQ[1]=1. HSPLIT[1] pulse -> granted again per RR order.
5. HREADY=0 for 3 cycles with pending requests -> HGRANT/HMASTER frozen. Release -> update on first HREADY=1 edge.
6. HRESET=1 mid-locked burst with split_mask=4'b0100 -> next cycle HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0, split_mask cleared.
